calc_sequencer: RTL and testbench



---
 rtl/calc_sequencer.sv | 171 +++++++++++++++++
 tb/tb_calc_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// Button-driven calculator sequencer: one shared W+1-bit adder runs add, subtract and shift-add multiply.
// Optional build macro CALC_SEQ_ACCUM_EN makes add/sub accumulate into the held result instead of using op_a.
module calc_sequencer #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   op_a,
  input  logic [W-1:0]   op_b,
  input  logic           cmd_clr,
  input  logic           cmd_add,
  input  logic           cmd_sub,
  input  logic           cmd_mul,
  output logic [2*W-1:0] result,
  output logic           flag,
  output logic           busy,
  output logic           done,
  output logic [2:0]     dbg_state
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    EXEC_ADD = 3'd1,
    EXEC_SUB = 3'd2,
    EXEC_MUL = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t         state, state_next;
  logic           clr_q, add_q, sub_q, mul_q;
  logic           clr_edge, add_edge, sub_edge, mul_edge;
  logic           accept, go_add, go_sub, go_mul;
  logic [W-1:0]   a_q, b_q;
  logic [2*W-1:0] acc;
  logic [CW-1:0]  iter;
  logic           last_iter;
  logic [W-1:0]   acc_src, add_x, add_y;
  logic           add_cin;
  logic [W:0]     sum;
  logic [2*W-1:0] mul_next;

  // History registers reset high so a button held through reset does not fire.
  assign clr_edge = cmd_clr & ~clr_q;
  assign add_edge = cmd_add & ~add_q;
  assign sub_edge = cmd_sub & ~sub_q;
  assign mul_edge = cmd_mul & ~mul_q;

  assign accept = ((state == IDLE) || (state == DONE)) && !clr_edge;
  assign go_mul = accept & mul_edge;
  assign go_sub = accept & sub_edge & ~mul_edge;
  assign go_add = accept & add_edge & ~mul_edge & ~sub_edge;

  assign last_iter = (iter == CW'(W - 1));
  assign dbg_state = state;

`ifdef CALC_SEQ_ACCUM_EN
  assign acc_src = result[W-1:0];
`else
  assign acc_src = a_q;
`endif

  // Shared adder: add, subtract as x + ~y + 1, or one multiply partial-sum step.
  always_comb begin
    add_x   = acc_src;
    add_y   = b_q;
    add_cin = 1'b0;
    case (state)
      EXEC_SUB: begin
        add_y   = ~b_q;
        add_cin = 1'b1;
      end
      EXEC_MUL: begin
        add_x = acc[2*W-1:W];
        add_y = acc[0] ? a_q : '0;
      end
      default: ;
    endcase
  end

  assign sum      = {1'b0, add_x} + {1'b0, add_y} + {{W{1'b0}}, add_cin};
  assign mul_next = {sum, acc[W-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (go_mul)      state_next = EXEC_MUL;
        else if (go_sub) state_next = EXEC_SUB;
        else if (go_add) state_next = EXEC_ADD;
        else             state_next = IDLE;
      end
      EXEC_ADD, EXEC_SUB: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      EXEC_MUL: begin
        busy = 1'b1;
        if (last_iter) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
    if (clr_edge) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clr_q  <= 1'b1;
      add_q  <= 1'b1;
      sub_q  <= 1'b1;
      mul_q  <= 1'b1;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      iter   <= '0;
      result <= '0;
      flag   <= 1'b0;
    end else begin
      clr_q <= cmd_clr;
      add_q <= cmd_add;
      sub_q <= cmd_sub;
      mul_q <= cmd_mul;
      if (clr_edge) begin
        acc    <= '0;
        iter   <= '0;
        result <= '0;
        flag   <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (go_add || go_sub || go_mul) begin
              a_q  <= op_a;
              b_q  <= op_b;
              acc  <= {{W{1'b0}}, op_b};
              iter <= '0;
            end
          end
          EXEC_ADD: begin
            result <= {{(W-1){1'b0}}, sum};
            flag   <= sum[W];
          end
          EXEC_SUB: begin
            result <= {{W{1'b0}}, sum[W-1:0]};
            flag   <= ~sum[W];
          end
          EXEC_MUL: begin
            acc <= mul_next;
            if (last_iter) begin
              result <= mul_next;
              flag   <= |mul_next[2*W-1:W];
              iter   <= '0;
            end else begin
              iter <= iter + CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: hand-computed vectors, immediate-assertion checks, done-pulse scoreboard.
module tb_calc_sequencer;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   op_a, op_b;
  logic           cmd_clr, cmd_add, cmd_sub, cmd_mul;
  logic [2*W-1:0] result;
  logic           flag, busy, done;
  logic [2:0]     dbg_state;

  int total = 0;
  int bad   = 0;
  logic [2*W:0]   exp_q[$];
  logic [2*W:0]   exp_v;
  logic [2*W-1:0] held;

  calc_sequencer #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .op_a(op_a), .op_b(op_b),
    .cmd_clr(cmd_clr), .cmd_add(cmd_add), .cmd_sub(cmd_sub), .cmd_mul(cmd_mul),
    .result(result), .flag(flag), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;

  // ---- driver tasks ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [W-1:0] a, input logic [W-1:0] b);
    op_a = a;
    op_b = b;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // ---- scoreboard: every done pulse must match the next queued {flag,result} ----
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL done_unexpected observed=done expected=no_done result=0x%0h", result);
      end
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        total++;
        assert ({flag, result} === exp_v) else begin
          bad++;
          $error("FAIL sb_result observed=0x%0h expected=0x%0h", {flag, result}, exp_v);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    cmd_clr = 1'b0; cmd_add = 1'b1; cmd_sub = 1'b0; cmd_mul = 1'b0;
    set_ops(8'h00, 8'h00);

    // Reset with cmd_add held; release and keep it held: nothing must fire.
    repeat (3) tick();
    chk("rst_result", result, 0);
    chk("rst_flag", flag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("held_add_busy", busy, 0);
      chk("held_add_state", dbg_state, 0);
    end
    chk("held_add_result", result, 0);
    cmd_add = 1'b0;
    tick();

`ifdef CALC_SEQ_ACCUM_EN
    // Running accumulator: clr, then +3 three times, then -3.
    cmd_clr = 1'b1; tick(); cmd_clr = 1'b0; tick();
    chk("acc_clr", result, 0);
    set_ops(8'h55, 8'h03);
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back({1'b0, 16'(3 * i)});
      cmd_add = 1'b1; tick(); cmd_add = 1'b0; tick();
      chk("acc_add", result, 3 * i);
      chk("acc_add_done", done, 1);
      tick();
    end
    exp_q.push_back({1'b0, 16'h0006});
    cmd_sub = 1'b1; tick(); cmd_sub = 1'b0; tick();
    chk("acc_sub", result, 16'h0006);
    chk("acc_sub_flag", flag, 0);
    tick();
    // add and sub together: sub wins (6 - 3).
    exp_q.push_back({1'b0, 16'h0003});
    cmd_add = 1'b1; cmd_sub = 1'b1; tick(); cmd_add = 1'b0; cmd_sub = 1'b0; tick();
    chk("prio_sub_result", result, 16'h0003);
    tick();
    held = 16'h0003;
`else
    // ADD with carry: busy for exactly one cycle, done pulse the next.
    set_ops(8'hC8, 8'h64);
    exp_q.push_back({1'b1, 16'h012C});
    cmd_add = 1'b1; tick();
    chk("add_busy", busy, 1);
    chk("add_state", dbg_state, 1);
    tick();
    chk("add_result", result, 16'h012C);
    chk("add_flag", flag, 1);
    chk("add_done", done, 1);
    chk("add_busy_off", busy, 0);
    cmd_add = 1'b0; tick();
    chk("add_done_off", done, 0);
    chk("add_state_idle", dbg_state, 0);
    chk("add_held", result, 16'h012C);

    // SUB with borrow, then a second SUB accepted while in DONE.
    set_ops(8'h05, 8'h07);
    exp_q.push_back({1'b1, 16'h00FE});
    cmd_sub = 1'b1; tick(); cmd_sub = 1'b0; tick();
    chk("sub1_result", result, 16'h00FE);
    chk("sub1_flag", flag, 1);
    chk("sub1_state_done", dbg_state, 4);
    set_ops(8'h07, 8'h05);
    exp_q.push_back({1'b0, 16'h0002});
    cmd_sub = 1'b1; tick();
    chk("sub2_accept_in_done", dbg_state, 2);
    chk("sub2_done_off", done, 0);
    tick();
    chk("sub2_result", result, 16'h0002);
    chk("sub2_flag", flag, 0);
    chk("sub2_done", done, 1);
    cmd_sub = 1'b0; tick();

    // add and sub together from IDLE: sub wins (9 - 4, not 9 + 4).
    set_ops(8'h09, 8'h04);
    exp_q.push_back({1'b0, 16'h0005});
    cmd_add = 1'b1; cmd_sub = 1'b1; tick();
    chk("prio_state", dbg_state, 2);
    cmd_add = 1'b0; cmd_sub = 1'b0; tick();
    chk("prio_sub_result", result, 16'h0005);
    tick();
    held = 16'h0005;
`endif

    // MUL FF*FF, switches changed mid-multiply.
    set_ops(8'hFF, 8'hFF);
    exp_q.push_back({1'b1, 16'hFE01});
    cmd_mul = 1'b1; tick();
    chk("mul_state", dbg_state, 3);
    cmd_mul = 1'b0;
    set_ops(8'h00, 8'h00);
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("mul_busy", busy, 1);
      chk("mul_result_held", result, held);
    end
    tick();
    chk("mul_result", result, 16'hFE01);
    chk("mul_flag", flag, 1);
    chk("mul_done", done, 1);
    chk("mul_busy_off", busy, 0);
    tick();
    chk("mul_done_off", done, 0);
    chk("mul_state_idle", dbg_state, 0);

    // MUL aborted: add at k+3 ignored, clr at k+4 clears with no done.
    set_ops(8'h10, 8'h10);
    cmd_mul = 1'b1; tick(); cmd_mul = 1'b0;
    tick(); tick();
    cmd_add = 1'b1; tick();
    chk("abort_add_ignored_state", dbg_state, 3);
    chk("abort_add_ignored_busy", busy, 1);
    cmd_clr = 1'b1; tick();
    chk("clr_result", result, 0);
    chk("clr_flag", flag, 0);
    chk("clr_state", dbg_state, 0);
    chk("clr_busy", busy, 0);
    chk("clr_done", done, 0);
    cmd_clr = 1'b0; cmd_add = 1'b0;
    repeat (3) tick();
    chk("clr_stays_idle", dbg_state, 0);
    chk("clr_result_held", result, 0);

    // MUL with zero operands still takes the full W cycles.
    set_ops(8'h00, 8'h00);
    exp_q.push_back({1'b0, 16'h0000});
    cmd_mul = 1'b1; tick(); cmd_mul = 1'b0;
    repeat (7) tick();
    chk("zmul_busy_k7", busy, 1);
    tick();
    chk("zmul_done", done, 1);
    chk("zmul_result", result, 0);
    chk("zmul_flag", flag, 0);
    tick();

    // ---- final report ----
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
